// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and helpers for the streaming FFT datapath.
// Imported by the butterfly and the complex multiplier.
package fft_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TW_W_DEF   = 16;

   // Twiddle grows one bit so that negating -1.0 stays exact.
   localparam int W_GROW = 1;
   // Scaled product width over the sample width.
   localparam int P_GROW = 2;
   // Butterfly sum width over the sample width.
   localparam int S_GROW = 3;

   localparam int SAT_W = 64;

   typedef logic signed [SAT_W-1:0] sat_t;

   // Clamp a sign-extended value to out_w bits; clip flags a clamp.
   function automatic sat_t saturate(
      input  sat_t v,
      input  int   out_w,
      output logic clip
   );
      sat_t hi;
      sat_t lo;
      hi   = (sat_t'(1) <<< (out_w - 1)) - sat_t'(1);
      lo   = -(sat_t'(1) <<< (out_w - 1));
      clip = 1'b0;
      saturate = v;
      if (v > hi) begin
         saturate = hi;
         clip     = 1'b1;
      end else if (v < lo) begin
         saturate = lo;
         clip     = 1'b1;
      end
   endfunction

endpackage

// File: rtl/fft_cmul.sv
// fft_cmul: registered complex multiply B*W with optional conjugation.
// Products are floor-scaled back to sample range plus two guard bits.
module fft_cmul
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TW_W   = TW_W_DEF
) (
   input  logic                          clk,
   input  logic                          ce,
   input  logic                          conj,
   input  logic signed [DATA_W-1:0]      br,
   input  logic signed [DATA_W-1:0]      bi,
   input  logic signed [TW_W-1:0]        wr,
   input  logic signed [TW_W-1:0]        wi,
   output logic signed [DATA_W+P_GROW-1:0] pr,
   output logic signed [DATA_W+P_GROW-1:0] pi
);

   localparam int WE_W  = TW_W + W_GROW;
   localparam int ACC_W = DATA_W + WE_W + 1;
   localparam int P_W   = DATA_W + P_GROW;

   logic signed [WE_W-1:0]  wr_e;
   logic signed [WE_W-1:0]  wi_e;
   logic signed [ACC_W-1:0] acc_re;
   logic signed [ACC_W-1:0] acc_im;

   // Conjugate the twiddle and form full-precision products
   always_comb begin
      wr_e   = WE_W'(wr);
      wi_e   = conj ? -WE_W'(wi) : WE_W'(wi);
      acc_re = ACC_W'(br) * ACC_W'(wr_e)
             - ACC_W'(bi) * ACC_W'(wi_e);
      acc_im = ACC_W'(br) * ACC_W'(wi_e)
             + ACC_W'(bi) * ACC_W'(wr_e);
   end

   // Register the floor-scaled products when the pipe advances
   always_ff @(posedge clk) begin
      if (ce) begin
         pr <= P_W'(acc_re >>> (TW_W - 1));
         pi <= P_W'(acc_im >>> (TW_W - 1));
      end
   end

endmodule

// File: rtl/fft_bfly_r2.sv
// fft_bfly_r2: pipelined radix-2 DIT butterfly, X = A + BW, Y = A - BW.
// Three stages under one global enable, per-transaction scaling, sticky ovf.
module fft_bfly_r2
   import fft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TW_W   = TW_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic signed [TW_W-1:0]   w_re,
   input  logic signed [TW_W-1:0]   w_im,
   input  logic                     inverse,
   input  logic [1:0]               scale_shift,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] x_re,
   output logic signed [DATA_W-1:0] x_im,
   output logic signed [DATA_W-1:0] y_re,
   output logic signed [DATA_W-1:0] y_im,
   output logic                     ovf,
   input  logic                     clr_ovf
);

   localparam int P_W = DATA_W + P_GROW;
   localparam int S_W = DATA_W + S_GROW;

   logic ce;
   logic v1;
   logic v2;

   logic signed [DATA_W-1:0] a1_re, a1_im;
   logic signed [DATA_W-1:0] b1_re, b1_im;
   logic signed [TW_W-1:0]   w1_re, w1_im;
   logic                     inv1;
   logic [1:0]               sh1;

   logic signed [DATA_W-1:0] a2_re, a2_im;
   logic signed [P_W-1:0]    p2_re, p2_im;
   logic [1:0]               sh2;

   logic signed [S_W-1:0]    sum [4];
   logic signed [S_W-1:0]    shf [4];
   logic signed [DATA_W-1:0] res [4];
   logic [3:0]               clip;
   sat_t                     st;

   assign ce       = !out_valid | out_ready;
   assign in_ready = ce;

   // Valid bits march together; bubbles advance, never compress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else if (ce) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
      end
   end

   // S1 captures operands, twiddle and per-transaction controls
   always_ff @(posedge clk) begin
      if (ce) begin
         a1_re <= a_re;
         a1_im <= a_im;
         b1_re <= b_re;
         b1_im <= b_im;
         w1_re <= w_re;
         w1_im <= w_im;
         inv1  <= inverse;
         sh1   <= scale_shift;
      end
   end

   fft_cmul #(
      .DATA_W (DATA_W),
      .TW_W   (TW_W)
   ) u_cmul (
      .clk  (clk),
      .ce   (ce),
      .conj (inv1),
      .br   (b1_re),
      .bi   (b1_im),
      .wr   (w1_re),
      .wi   (w1_im),
      .pr   (p2_re),
      .pi   (p2_im)
   );

   // S2 carries A and the shift alongside the products
   always_ff @(posedge clk) begin
      if (ce) begin
         a2_re <= a1_re;
         a2_im <= a1_im;
         sh2   <= sh1;
      end
   end

   // Add/subtract, scale, then clamp each output component
   always_comb begin
      st     = '0;
      clip   = '0;
      sum[0] = S_W'(a2_re) + S_W'(p2_re);
      sum[1] = S_W'(a2_im) + S_W'(p2_im);
      sum[2] = S_W'(a2_re) - S_W'(p2_re);
      sum[3] = S_W'(a2_im) - S_W'(p2_im);
      for (int k = 0; k < 4; k++) begin
         shf[k] = sum[k] >>> sh2;
         st     = saturate(SAT_W'(shf[k]), DATA_W, clip[k]);
         res[k] = DATA_W'(st);
      end
   end

   // S3 output registers read zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_re <= '0;
         x_im <= '0;
         y_re <= '0;
         y_im <= '0;
      end else if (ce) begin
         x_re <= res[0];
         x_im <= res[1];
         y_re <= res[2];
         y_im <= res[3];
      end
   end

   // Sticky overflow; a fresh clip beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (ce && v2 && (|clip)) begin
         ovf <= 1'b1;
      end else if (clr_ovf) begin
         ovf <= 1'b0;
      end
   end

endmodule
